// File: rtl/ps2_kbd_tx_if.sv
// Scan-code handshake between a code producer and the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: queues scan codes and serialises them as
// 11-bit frames (start, 8 data LSB first, odd parity, stop) on ps2_clk/ps2_data.
module ps2_kbd_tx #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int DEPTH       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  ps2_kbd_tx_if.slave            in_port,
  input  logic                   inhibit,
  output logic                   ps2_clk,
  output logic                   ps2_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW-1:0] hc;
  logic [3:0]    bi;
  logic [10:0]   frame;
  logic [7:0]    head;

  assign full             = (count == (AW+1)'(DEPTH));
  assign empty            = (count == '0);
  assign in_port.in_ready = !full;
  assign push             = in_port.in_valid && !full;
  // Inhibit only gates the decision to start a frame; it never aborts one.
  assign pop              = (state == IDLE) && !empty && !inhibit;
  assign head             = mem[rd_ptr];
  assign busy             = (state != IDLE);
  assign fifo_count       = count;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_port.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Line outputs are registered here so they only move on phase boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      hc       <= '0;
      bi       <= '0;
      frame    <= '1;
    end else begin
      case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (pop) begin
            frame    <= {1'b1, ~^head, head, 1'b0};
            ps2_data <= 1'b0;
            hc       <= '0;
            bi       <= '0;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (hc == CW'(HALF_PERIOD - 1)) begin
            hc      <= '0;
            ps2_clk <= 1'b0;
            state   <= LOW;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        LOW: begin
          if (hc == CW'(HALF_PERIOD - 1)) begin
            hc      <= '0;
            ps2_clk <= 1'b1;
            if (bi == 4'd10) begin
              ps2_data <= 1'b1;
              state    <= GAP;
            end else begin
              bi       <= bi + 4'd1;
              ps2_data <= frame[bi + 4'd1];
              state    <= HIGH;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        GAP: begin
          if (hc == CW'(GAP_CYCLES - 1)) begin
            hc    <= '0;
            state <= IDLE;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a waveform-level model predicts every cycle of the
// PS/2 lines, plus literal frame/timing expectations for directed scenarios.
module tb_ps2_kbd_tx;

  localparam int HALF_PERIOD = 4;
  localparam int GAP_CYCLES  = 8;
  localparam int DEPTH       = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inhibit = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  ps2_kbd_tx_if ifc ();

  ps2_kbd_tx #(
    .HALF_PERIOD(HALF_PERIOD),
    .GAP_CYCLES (GAP_CYCLES),
    .DEPTH      (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_port   (ifc),
    .inhibit   (inhibit),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Model: queued codes plus a queue of future {busy, clk, data} cycles.
  logic [7:0] codeQ [$];
  logic [2:0] waveQ [$];
  logic [2:0] cur = 3'b011;
  bit         modelLive = 0;
  bit         pushOk;

  task automatic buildWave(input logic [7:0] d);
    logic b;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      b = 1'b0;
      else if (i <= 8) b = d[i-1];
      else if (i == 9) b = ($countones(d) % 2 == 0);
      else             b = 1'b1;
      for (int k = 0; k < HALF_PERIOD; k++) waveQ.push_back({1'b1, 1'b1, b});
      for (int k = 0; k < HALF_PERIOD; k++) waveQ.push_back({1'b1, 1'b0, b});
    end
    for (int k = 0; k < GAP_CYCLES; k++) waveQ.push_back(3'b111);
    waveQ.push_back(3'b011);
  endtask

  always @(posedge clock) begin
    if (reset) begin
      codeQ.delete();
      waveQ.delete();
      cur = 3'b011;
      modelLive = 1;
    end else if (modelLive) begin
      pushOk = ifc.in_valid && (codeQ.size() < DEPTH);
      if (waveQ.size() > 0) begin
        cur = waveQ.pop_front();
      end else if (codeQ.size() > 0 && !inhibit) begin
        buildWave(codeQ.pop_front());
        cur = waveQ.pop_front();
      end else begin
        cur = 3'b011;
      end
      if (pushOk) codeQ.push_back(ifc.in_data);
    end
  end

  always @(negedge clock) begin
    if (modelLive) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, cur[2]});
      checkOutput("ps2_clk", {31'b0, ps2_clk}, {31'b0, cur[1]});
      checkOutput("ps2_data", {31'b0, ps2_data}, {31'b0, cur[0]});
      checkOutput("fifo_count", {28'b0, fifo_count}, 32'(codeQ.size()));
      checkOutput("in_ready", {31'b0, ifc.in_ready}, {31'b0, codeQ.size() < DEPTH});
    end
  end

  // Line monitor: decodes frames at ps2_clk falling edges and times busy runs.
  int          fallCount = 0;
  int          cycle = 0;
  int          nb = 0;
  logic        prevClk = 1'b1;
  logic        prevBusy = 1'b0;
  logic [10:0] acc = '0;
  logic [10:0] frames [$];
  int          spans [$];
  int          runs [$];
  int          gaps [$];
  int          runStart = 0;
  int          lastLow = 0;
  int          lastFall = 0;

  always @(posedge clock) begin
    #1;
    cycle++;
    if (prevClk === 1'b1 && ps2_clk === 1'b0) begin
      fallCount++;
      acc[nb] = ps2_data;
      nb++;
      if (nb == 11) begin
        frames.push_back(acc);
        nb = 0;
      end
    end
    if (busy === 1'b1 && prevBusy === 1'b0) begin
      gaps.push_back(cycle - lastFall);
      runStart = cycle;
    end
    if (busy === 1'b1 && ps2_clk === 1'b0) lastLow = cycle;
    if (busy === 1'b0 && prevBusy === 1'b1) begin
      if (nb == 0) begin
        spans.push_back(lastLow - runStart + 1);
        runs.push_back(cycle - runStart);
      end
      lastFall = cycle;
      nb = 0;
    end
    prevClk = ps2_clk;
    prevBusy = busy;
  end

  function automatic logic [31:0] frameAt(input int i);
    return (i < frames.size()) ? {21'b0, frames[i]} : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] spanAt(input int i);
    return (i < spans.size()) ? 32'(spans[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] runAt(input int i);
    return (i < runs.size()) ? 32'(runs[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] gapAt(input int i);
    return (i < gaps.size()) ? 32'(gaps[i]) : 32'hFFFF_FFFF;
  endfunction

  // Called at a negedge; returns at the negedge after the code was accepted.
  task automatic applyStimulus(input logic [7:0] code);
    int guard = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = code;
    while (!ifc.in_ready && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 3000) checkOutput("push_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  task automatic waitIdle(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clock);
      n++;
      if (!busy && fifo_count == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] batch [9] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80, 8'h01, 8'h7E, 8'h3C, 8'hC3};

  initial begin
    int guard;
    int base;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("rst_ps2_clk", {31'b0, ps2_clk}, 32'd1);
    checkOutput("rst_ps2_data", {31'b0, ps2_data}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_count", {28'b0, fifo_count}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);

    // Single 8'h1C frame.
    applyStimulus(8'h1C);
    ifc.in_valid = 1'b0;
    waitIdle(400);
    checkOutput("frame_1C", frameAt(0), 32'h438);
    checkOutput("span_1C", spanAt(0), 32'd88);
    checkOutput("busy_run_1C", runAt(0), 32'd96);

    // Back-to-back 1C, F0, 1C.
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    ifc.in_valid = 1'b0;
    waitIdle(800);
    checkOutput("b2b_frame1", frameAt(1), 32'h438);
    checkOutput("b2b_frame2", frameAt(2), 32'h7E0);
    checkOutput("b2b_frame3", frameAt(3), 32'h438);
    checkOutput("b2b_idle_gap2", gapAt(2), 32'd1);
    checkOutput("b2b_idle_gap3", gapAt(3), 32'd1);
    checkOutput("b2b_run2", runAt(2), 32'd96);

    // Fill the FIFO while inhibited; the ninth code is held by the producer.
    inhibit = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(batch[i]);
    checkOutput("full_in_ready", {31'b0, ifc.in_ready}, 32'd0);
    checkOutput("full_count", {28'b0, fifo_count}, 32'd8);
    ifc.in_valid = 1'b1;
    ifc.in_data  = batch[8];
    repeat (5) @(negedge clock);
    checkOutput("held_count", {28'b0, fifo_count}, 32'd8);
    checkOutput("held_busy", {31'b0, busy}, 32'd0);
    inhibit = 1'b0;
    guard = 0;
    while (!ifc.in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!ifc.in_ready) checkOutput("ready_return", 32'd0, 32'd1);
    @(negedge clock);
    ifc.in_valid = 1'b0;
    waitIdle(2000);
    checkOutput("batch_first", frameAt(4), 32'h600);
    checkOutput("batch_ninth", frameAt(12), 32'h786);
    checkOutput("batch_frames", 32'(frames.size()), 32'd13);

    // Inhibit asserted mid-frame: 1B completes, F0 waits.
    applyStimulus(8'h1B);
    applyStimulus(8'hF0);
    ifc.in_valid = 1'b0;
    repeat (30) @(negedge clock);
    inhibit = 1'b1;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    repeat (20) @(negedge clock);
    checkOutput("inh_busy", {31'b0, busy}, 32'd0);
    checkOutput("inh_count", {28'b0, fifo_count}, 32'd1);
    checkOutput("inh_frame_1B", frameAt(13), 32'h636);
    inhibit = 1'b0;
    waitIdle(400);
    checkOutput("inh_frame_F0", frameAt(14), 32'h7E0);

    // Reset in the HIGH phase of bit 5 with two codes still queued.
    applyStimulus(8'hA1);
    applyStimulus(8'hB2);
    applyStimulus(8'hC3);
    ifc.in_valid = 1'b0;
    base = fallCount;
    guard = 0;
    while (fallCount < base + 5 && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    repeat (HALF_PERIOD) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_ps2_clk", {31'b0, ps2_clk}, 32'd1);
    checkOutput("abort_ps2_data", {31'b0, ps2_data}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_count", {28'b0, fifo_count}, 32'd0);
    repeat (200) @(negedge clock);
    checkOutput("abort_falls", 32'(fallCount), 32'd170);
    checkOutput("abort_frames", 32'(frames.size()), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
